dcache: RTL and testbench



---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_store_merge.sv | 40 ++++
 rtl/dcache.sv | 207 ++++++++++++++++++++
 tb/tb_dcache.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned LINE_WORDS  = 8;
  localparam int unsigned LINE_ADDR_W = 14;
  localparam int unsigned WORD_W      = 64;
  localparam int unsigned BEAT_W      = 3;

  localparam logic [1:0] ST_BYTE   = 2'b00;
  localparam logic [1:0] ST_HALF   = 2'b01;
  localparam logic [1:0] ST_WORD   = 2'b10;
  localparam logic [1:0] ST_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WBACK,
    GAP,
    REFILL
  } state_t;

  // Latched request payload, held while a miss is serviced.
  typedef struct packed {
    logic [BEAT_W-1:0] wsel;
    logic [2:0]        off;
    logic [WORD_W-1:0] data;
    logic              rw_n;
    logic [1:0]        st;
  } req_t;

endpackage

// File: rtl/dcache_store_merge.sv
// Merges right-justified store data into a big-endian 64-bit word.
module dcache_store_merge
  import dcache_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        offset,
  input  logic [1:0]        store_type,
  output logic [WORD_W-1:0] merged_c
);

  logic [WORD_W-1:0] mask;
  logic [5:0]        sh;

  // Shift places the lane's LSB at (8 - aligned_offset - size) bytes; low offset bits drop.
  always_comb begin
    mask = '1;
    sh   = '0;
    case (store_type)
      ST_BYTE: begin
        mask = 64'h0000_0000_0000_00FF;
        sh   = {~offset, 3'b000};
      end
      ST_HALF: begin
        mask = 64'h0000_0000_0000_FFFF;
        sh   = {~offset[2:1], 1'b0, 3'b000};
      end
      ST_WORD: begin
        mask = 64'h0000_0000_FFFF_FFFF;
        sh   = {~offset[2], 2'b00, 3'b000};
      end
      default: begin
        mask = '1;
        sh   = '0;
      end
    endcase
    merged_c = (old_word & ~(mask << sh)) | ((data & mask) << sh);
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache serving the Mem stage.
// Misses refill a 64-byte line over an 8-beat memory burst, writing back a dirty victim first.
module dcache #(
  parameter int unsigned SETS        = 64,
  parameter int unsigned LINE_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dc_req,
  input  logic [57:0]            dc_line_addr,
  input  logic [2:0]             dc_word_select,
  input  logic [2:0]             dc_byte_offset,
  input  logic [63:0]            dc_data_to_cache,
  input  logic                   dc_read_write_n,
  input  logic [1:0]             store_type,
  input  logic [1:0]             load_type,
  output logic                   dc_ack,
  output logic [63:0]            dc_data_from_cache,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [LINE_ADDR_W-1:0] mem_line_addr,
  output logic [63:0]            mem_wdata,
  input  logic                   mem_wready,
  input  logic [63:0]            mem_rdata,
  input  logic                   mem_rvalid
);
  import dcache_pkg::*;

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = (LINE_ADDR_W > IDX_W) ? (LINE_ADDR_W - IDX_W) : 1;

  state_t                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [LINE_ADDR_W-1:0] req_line_q;
  req_t                   req_q;

  logic [SETS-1:0]        valid_q;
  logic [SETS-1:0]        dirty_q;
  logic [TAG_W-1:0]       tag_q  [SETS];
  logic [WORD_W-1:0]      data_q [SETS][LINE_WORDS];

  logic                   ack_d;
  logic [WORD_W-1:0]      rdata_d;
  logic                   mem_req_d, mem_we_d;
  logic [LINE_ADDR_W-1:0] maddr_d;
  logic [WORD_W-1:0]      wdata_d;

  logic                   latch_c, store_we_c, refill_we_c, wb_done_c, refill_done_c;
  logic [IDX_W-1:0]       in_idx, r_idx;
  logic [TAG_W-1:0]       in_tag, r_tag;
  logic                   in_hit_c, hit_c;
  logic [WORD_W-1:0]      merged_c;
  logic [LINE_ADDR_W-1:0] victim_line;

  logic                   unused_c;
  assign unused_c = ^{dc_line_addr[57:LINE_ADDR_W], load_type};

  assign in_idx      = dc_line_addr[IDX_W-1:0];
  assign in_tag      = TAG_W'(dc_line_addr[LINE_ADDR_W-1:0] >> IDX_W);
  assign in_hit_c    = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign r_idx       = req_line_q[IDX_W-1:0];
  assign r_tag       = TAG_W'(req_line_q >> IDX_W);
  assign hit_c       = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign victim_line = LINE_ADDR_W'({tag_q[r_idx], r_idx});

  dcache_store_merge u_merge (
    .old_word   (data_q[r_idx][req_q.wsel]),
    .data       (req_q.data),
    .offset     (req_q.off),
    .store_type (req_q.st),
    .merged_c   (merged_c)
  );

  // Next state plus next values of the registered outputs; the ack is looked ahead
  // one cycle so it appears during the COMPARE cycle.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    ack_d         = 1'b0;
    rdata_d       = '0;
    mem_req_d     = 1'b0;
    mem_we_d      = mem_we;
    maddr_d       = mem_line_addr;
    wdata_d       = mem_wdata;
    latch_c       = 1'b0;
    store_we_c    = 1'b0;
    refill_we_c   = 1'b0;
    wb_done_c     = 1'b0;
    refill_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (dc_req) begin
          latch_c = 1'b1;
          state_d = COMPARE;
          if (in_hit_c) begin
            ack_d   = 1'b1;
            rdata_d = data_q[in_idx][dc_word_select];
          end
        end
      end
      COMPARE: begin
        beat_d = '0;
        if (hit_c) begin
          state_d    = IDLE;
          store_we_c = !req_q.rw_n;
        end else if (valid_q[r_idx] && dirty_q[r_idx]) begin
          state_d   = WBACK;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
          maddr_d   = victim_line;
          wdata_d   = data_q[r_idx][0];
        end else begin
          state_d   = REFILL;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          maddr_d   = req_line_q;
        end
      end
      WBACK: begin
        mem_req_d = 1'b1;
        if (mem_wready) begin
          if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
            wb_done_c = 1'b1;
            mem_req_d = 1'b0;
            beat_d    = '0;
            state_d   = GAP;
          end else begin
            beat_d  = beat_q + 3'd1;
            wdata_d = data_q[r_idx][beat_q + 3'd1];
          end
        end
      end
      GAP: begin
        state_d   = REFILL;
        mem_req_d = 1'b1;
        mem_we_d  = 1'b0;
        maddr_d   = req_line_q;
      end
      REFILL: begin
        mem_req_d = 1'b1;
        if (mem_rvalid) begin
          refill_we_c = 1'b1;
          if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
            refill_done_c = 1'b1;
            mem_req_d     = 1'b0;
            beat_d        = '0;
            state_d       = COMPARE;
            ack_d         = 1'b1;
            rdata_d       = (req_q.wsel == beat_q) ? mem_rdata : data_q[r_idx][req_q.wsel];
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, line status bits and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      beat_q             <= '0;
      valid_q            <= '0;
      dirty_q            <= '0;
      dc_ack             <= 1'b0;
      dc_data_from_cache <= '0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_line_addr      <= '0;
      mem_wdata          <= '0;
    end else begin
      state_q            <= state_d;
      beat_q             <= beat_d;
      dc_ack             <= ack_d;
      dc_data_from_cache <= rdata_d;
      mem_req            <= mem_req_d;
      mem_we             <= mem_we_d;
      mem_line_addr      <= maddr_d;
      mem_wdata          <= wdata_d;
      if (store_we_c)    dirty_q[r_idx] <= 1'b1;
      if (wb_done_c)     dirty_q[r_idx] <= 1'b0;
      if (refill_done_c) begin
        valid_q[r_idx] <= 1'b1;
        dirty_q[r_idx] <= 1'b0;
      end
    end
  end

  // Request latch, tags and line data keep their contents across reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (latch_c) begin
        req_line_q <= dc_line_addr[LINE_ADDR_W-1:0];
        req_q.wsel <= dc_word_select;
        req_q.off  <= dc_byte_offset;
        req_q.data <= dc_data_to_cache;
        req_q.rw_n <= dc_read_write_n;
        req_q.st   <= store_type;
      end
      if (store_we_c)    data_q[r_idx][req_q.wsel] <= merged_c;
      if (refill_we_c)   data_q[r_idx][beat_q]     <= mem_rdata;
      if (refill_done_c) tag_q[r_idx]              <= r_tag;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a procedural memory responder plus hand-computed expectations.
module tb_dcache;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        dc_req;
  logic [57:0] dc_line_addr;
  logic [2:0]  dc_word_select;
  logic [2:0]  dc_byte_offset;
  logic [63:0] dc_data_to_cache;
  logic        dc_read_write_n;
  logic [1:0]  store_type;
  logic [1:0]  load_type;
  logic        dc_ack;
  logic [63:0] dc_data_from_cache;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_line_addr;
  logic [63:0] mem_wdata;
  logic        mem_wready;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;

  always #5 clk = ~clk;

  dcache #(.SETS(64), .LINE_ADDR_W(14)) dut (
    .clk                (clk),
    .reset              (reset),
    .dc_req             (dc_req),
    .dc_line_addr       (dc_line_addr),
    .dc_word_select     (dc_word_select),
    .dc_byte_offset     (dc_byte_offset),
    .dc_data_to_cache   (dc_data_to_cache),
    .dc_read_write_n    (dc_read_write_n),
    .store_type         (store_type),
    .load_type          (load_type),
    .dc_ack             (dc_ack),
    .dc_data_from_cache (dc_data_from_cache),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_line_addr      (mem_line_addr),
    .mem_wdata          (mem_wdata),
    .mem_wready         (mem_wready),
    .mem_rdata          (mem_rdata),
    .mem_rvalid         (mem_rvalid)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Backing memory: written-back words override the default (line << 12) + beat pattern.
  logic [63:0] mem [int];

  function automatic logic [63:0] mem_word(input logic [13:0] line, input int beat);
    int key;
    key = int'(line) * 8 + beat;
    if (mem.exists(key)) return mem[key];
    return (64'(line) << 12) + 64'(beat);
  endfunction

  logic [63:0] ack_data;
  logic [63:0] wb [8];
  logic [13:0] r_line, w_line;
  int          ack_cyc, n_r, n_w, last_r_cyc, first_r_cyc, last_w_cyc, hold_err;

  task automatic do_req(input logic [13:0] line, input logic [2:0] wsel, input logic [2:0] off,
                        input logic [63:0] data, input logic rw_n, input logic [1:0] st,
                        input int rst_beat);
    logic [63:0] prev_wdata;
    logic [13:0] prev_addr;
    int          stall, cyc;
    bit          done;
    n_r = 0; n_w = 0; stall = 0; cyc = 0; done = 1'b0; hold_err = 0;
    ack_cyc = -1; last_r_cyc = -1; first_r_cyc = -1; last_w_cyc = -1;
    ack_data = '0; r_line = '0; w_line = '0;
    prev_wdata = '0; prev_addr = '0;
    @(negedge clk);
    dc_req           = 1'b1;
    dc_line_addr     = {44'h5A5, line};
    dc_word_select   = wsel;
    dc_byte_offset   = off;
    dc_data_to_cache = data;
    dc_read_write_n  = rw_n;
    store_type       = st;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_rvalid = 1'b0;
      mem_wready = 1'b0;
      if (dc_ack) begin
        ack_data = dc_data_from_cache;
        ack_cyc  = cyc;
        done     = 1'b1;
        dc_req   = 1'b0;
      end else if (mem_req && mem_we) begin
        w_line = mem_line_addr;
        if (n_w == 4 && stall > 0 && (mem_wdata !== prev_wdata || mem_line_addr !== prev_addr))
          hold_err++;
        if (n_w == 4 && stall < 2) begin
          stall++;
          prev_wdata = mem_wdata;
          prev_addr  = mem_line_addr;
        end else begin
          mem_wready = 1'b1;
          wb[n_w] = mem_wdata;
          mem[int'(mem_line_addr) * 8 + n_w] = mem_wdata;
          n_w++;
          last_w_cyc = cyc;
        end
      end else if (mem_req && !mem_we) begin
        r_line = mem_line_addr;
        if (n_r == 0) first_r_cyc = cyc;
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(mem_line_addr, n_r);
        if (rst_beat >= 0 && n_r == rst_beat) begin
          reset = 1'b1;
          done  = 1'b1;
        end else begin
          n_r++;
          last_r_cyc = cyc;
        end
      end
    end
    check("req_completed", 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dc_req = 1'b0; dc_line_addr = '0; dc_word_select = '0; dc_byte_offset = '0;
    dc_data_to_cache = '0; dc_read_write_n = 1'b1; store_type = '0; load_type = '0;
    mem_wready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(dc_ack), 64'd0);
    check("rst_data", dc_data_from_cache, 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_line_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;

    // Clean miss on an invalid line
    do_req(14'h001, 3'd3, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t1_data", ack_data, 64'h1003);
    check("t1_rbeats", 64'(n_r), 64'd8);
    check("t1_rline", 64'(r_line), 64'h001);
    check("t1_wbeats", 64'(n_w), 64'd0);
    check("t1_ack_after_beat7", 64'(ack_cyc - last_r_cyc), 64'd1);
    @(negedge clk);
    check("t1_ack_pulse", 64'(dc_ack), 64'd0);
    check("t1_data_idle", dc_data_from_cache, 64'd0);

    // Hit
    do_req(14'h001, 3'd5, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t2_data", ack_data, 64'h1005);
    check("t2_latency", 64'(ack_cyc), 64'd1);
    check("t2_no_mem", 64'(n_r + n_w), 64'd0);

    // Byte store hit returns the pre-store word
    do_req(14'h001, 3'd3, 3'd2, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, ST_BYTE, -1);
    check("t3_old", ack_data, 64'h1003);
    check("t3_latency", 64'(ack_cyc), 64'd1);
    do_req(14'h001, 3'd3, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t3_reload", ack_data, 64'h0000_AB00_0000_1003);

    // Conflict miss with a dirty victim, beat 4 stalled twice
    do_req(14'h041, 3'd0, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t4_wbeats", 64'(n_w), 64'd8);
    check("t4_wline", 64'(w_line), 64'h001);
    check("t4_wb3", wb[3], 64'h0000_AB00_0000_1003);
    check("t4_wb7", wb[7], 64'h1007);
    check("t4_hold", 64'(hold_err), 64'd0);
    check("t4_gap", 64'(first_r_cyc - last_w_cyc), 64'd2);
    check("t4_rline", 64'(r_line), 64'h041);
    check("t4_rbeats", 64'(n_r), 64'd8);
    check("t4_data", ack_data, 64'h41000);

    // Line 1 comes back from memory with the written-back byte; victim 0x41 is clean
    do_req(14'h001, 3'd3, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t5_wbeats", 64'(n_w), 64'd0);
    check("t5_data", ack_data, 64'h0000_AB00_0000_1003);

    // Store miss: refill, replay returns refilled old word, then merges
    do_req(14'h005, 3'd2, 3'd0, 64'hDEAD_BEEF_0000_0001, 1'b0, ST_DOUBLE, -1);
    check("t6_rbeats", 64'(n_r), 64'd8);
    check("t6_old", ack_data, 64'h5002);
    do_req(14'h005, 3'd2, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t6_reload", ack_data, 64'hDEAD_BEEF_0000_0001);

    // Misaligned half and word stores are force-aligned
    do_req(14'h005, 3'd2, 3'd5, 64'h1234_5678_9ABC_CAFE, 1'b0, ST_HALF, -1);
    do_req(14'h005, 3'd2, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t7_half", ack_data, 64'hDEAD_BEEF_CAFE_0001);
    do_req(14'h005, 3'd1, 3'd3, 64'hAAAA_BBBB_1122_3344, 1'b0, ST_WORD, -1);
    check("t7_word_old", ack_data, 64'h5001);
    do_req(14'h005, 3'd1, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t7_word", ack_data, 64'h1122_3344_0000_5001);

    // Reset during refill beat 4 abandons the burst and invalidates everything
    do_req(14'h006, 3'd0, 3'd0, 64'd0, 1'b1, ST_DOUBLE, 4);
    @(negedge clk);
    check("t8_mem_req", 64'(mem_req), 64'd0);
    check("t8_ack", 64'(dc_ack), 64'd0);
    reset = 1'b0; dc_req = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    do_req(14'h006, 3'd0, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t8_rbeats", 64'(n_r), 64'd8);
    check("t8_data", ack_data, 64'h6000);
    do_req(14'h005, 3'd2, 3'd0, 64'd0, 1'b1, ST_DOUBLE, -1);
    check("t8_no_wb", 64'(n_w), 64'd0);
    check("t8_refetch", 64'(n_r), 64'd8);
    check("t8_lost_store", ack_data, 64'h5002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
